// File: rtl/tpu_norm_pkg.sv
// Shared constants and types for the TPU normalizer family.
// Widths, saturation limits and the denormalizer FSM state type.
package tpu_norm_pkg;

   localparam int DATA_W  = 32;
   localparam int GAIN_W  = 16;
   localparam int SHIFT_W = 5;
   localparam int NUM_W   = 64;

   localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
   localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      DIVIDE,
      FIX,
      DONE
   } denorm_state_t;

endpackage

// File: rtl/seq_divider.sv
// 64/16 unsigned restoring divider, one quotient bit per cycle, MSB first.
// Ports: clk, rst_n, start, num, den in; busy, done, quotient out.
// done is high during the final iteration; quotient is valid the cycle after.
module seq_divider
   import tpu_norm_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [NUM_W-1:0] num,
   input  logic [15:0]      den,
   output logic             busy,
   output logic             done,
   output logic [NUM_W-1:0] quotient
);

   logic [NUM_W-1:0] quo_q;
   logic [15:0]      den_q;
   logic [15:0]      rem_q;
   logic [5:0]       cnt_q;
   logic [16:0]      trial;
   logic [16:0]      sub;
   logic             ge;

   // Shift next numerator bit into the partial remainder and try a subtract.
   assign trial = {rem_q, quo_q[NUM_W-1]};
   assign sub   = trial - {1'b0, den_q};
   assign ge    = trial >= {1'b0, den_q};

   assign done     = busy && (cnt_q == 6'd63);
   assign quotient = quo_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quo_q <= '0;
         den_q <= '0;
         rem_q <= '0;
         cnt_q <= '0;
         busy  <= 1'b0;
      end else if (start) begin
         quo_q <= num;
         den_q <= den;
         rem_q <= '0;
         cnt_q <= '0;
         busy  <= 1'b1;
      end else if (busy) begin
         quo_q <= {quo_q[NUM_W-2:0], ge};
         // A failed trial is below den (<= 2^15), so 16 bits hold it.
         rem_q <= ge ? sub[15:0] : trial[15:0];
         cnt_q <= cnt_q + 6'd1;
         if (cnt_q == 6'd63)
            busy <= 1'b0;
      end
   end

endmodule

// File: rtl/denormalizer.sv
// Recovers x = ((y - bias) <<< shift) / gain with saturation, behind
// valid/ready handshakes. Ports: clk, rst_n, in_valid/in_ready, data_in,
// gain, bias, shift; out_valid/out_ready, data_out, div_by_zero, saturated.
module denormalizer
   import tpu_norm_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  data_in,
   input  logic [GAIN_W-1:0]  gain,
   input  logic [DATA_W-1:0]  bias,
   input  logic [SHIFT_W-1:0] shift,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  data_out,
   output logic               div_by_zero,
   output logic               saturated
);

   denorm_state_t state_q, state_d;

   logic [DATA_W-1:0]  y_q;
   logic [DATA_W-1:0]  bias_q;
   logic [GAIN_W-1:0]  gain_q;
   logic [SHIFT_W-1:0] shift_q;

   logic               neg_q;
   logic               zero_q;
   logic               dneg_q;

   logic [DATA_W:0]    diff;
   logic [NUM_W-1:0]   num;
   logic [NUM_W-1:0]   num_mag;
   logic [GAIN_W-1:0]  gain_mag;
   logic               accept;

   logic               div_busy;
   logic               div_done;
   logic [NUM_W-1:0]   quo;

   assign accept    = in_valid && in_ready;
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);

   // 33-bit difference, sign-extended to 64 before the shift.
   assign diff = {y_q[DATA_W-1], y_q} - {bias_q[DATA_W-1], bias_q};
   assign num  = {{(NUM_W-DATA_W-1){diff[DATA_W]}}, diff} << shift_q;

   assign num_mag  = num[NUM_W-1] ? (~num + 64'd1) : num;
   // -32768 negates to 0x8000, still correct as an unsigned divisor.
   assign gain_mag = gain_q[GAIN_W-1] ? (~gain_q + 16'd1) : gain_q;

   seq_divider u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (state_q == PREP && gain_q != '0),
      .num      (num_mag),
      .den      (gain_mag),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (quo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Zero gain bypasses the divider; FIX still selects its clamp value.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid) state_d = PREP;
         PREP:    state_d = (gain_q == '0) ? FIX : DIVIDE;
         DIVIDE:  if (div_done || !div_busy) state_d = FIX;
         FIX:     state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q     <= '0;
         bias_q  <= '0;
         gain_q  <= '0;
         shift_q <= '0;
      end else if (accept) begin
         y_q     <= data_in;
         bias_q  <= bias;
         gain_q  <= gain;
         shift_q <= shift;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_q  <= 1'b0;
         zero_q <= 1'b0;
         dneg_q <= 1'b0;
      end else if (state_q == PREP) begin
         neg_q  <= num[NUM_W-1] ^ gain_q[GAIN_W-1];
         zero_q <= (gain_q == '0);
         dneg_q <= diff[DATA_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out    <= '0;
         div_by_zero <= 1'b0;
         saturated   <= 1'b0;
      end else if (accept) begin
         div_by_zero <= 1'b0;
         saturated   <= 1'b0;
      end else if (state_q == FIX) begin
         if (zero_q) begin
            data_out    <= dneg_q ? SAT_MIN : SAT_MAX;
            div_by_zero <= 1'b1;
         end else if (neg_q) begin
            if (quo > 64'h8000_0000) begin
               data_out  <= SAT_MIN;
               saturated <= 1'b1;
            end else begin
               data_out <= ~quo[DATA_W-1:0] + 32'd1;
            end
         end else begin
            if (quo > 64'h7FFF_FFFF) begin
               data_out  <= SAT_MAX;
               saturated <= 1'b1;
            end else begin
               data_out <= quo[DATA_W-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_denormalizer.sv
// Directed self-checking bench for denormalizer.
// Hand-computed vectors cover latency, signs, zero gain, saturation, stalls, reset.
module tb_denormalizer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] data_in = '0;
   logic [15:0] gain = '0;
   logic [31:0] bias = '0;
   logic [4:0]  shift = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] data_out;
   logic        div_by_zero;
   logic        saturated;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   denormalizer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .data_in     (data_in),
      .gain        (gain),
      .bias        (bias),
      .shift       (shift),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .data_out    (data_out),
      .div_by_zero (div_by_zero),
      .saturated   (saturated)
   );

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] y,
                       input logic [31:0] b,
                       input logic [15:0] g,
                       input logic [4:0]  s,
                       output int lat);
      in_valid = 1'b1;
      data_in  = y;
      bias     = b;
      gain     = g;
      shift    = s;
      @(posedge clk); #1;
      in_valid = 1'b0;
      data_in  = 32'hDEAD_BEEF;
      bias     = 32'h1234_5678;
      gain     = 16'h0BAD;
      shift    = 5'd3;
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic retire(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_ovfall"}, {63'd0, out_valid}, 64'd0);
      check({tag, "_irdy"}, {63'd0, in_ready}, 64'd1);
   endtask

   initial begin
      int lat;
      logic [31:0] hold;
      logic ok;

      #12;
      check("rst_ovalid", {63'd0, out_valid}, 64'd0);
      check("rst_dout", {32'd0, data_out}, 64'd0);
      check("rst_flags", {62'd0, div_by_zero, saturated}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_irdy", {63'd0, in_ready}, 64'd1);

      // 1: 1000<<8 / 256
      send(32'd1000, 32'd0, 16'd256, 5'd8, lat);
      check("t1_lat", 64'(lat), 64'd66);
      check("t1_dout", {32'd0, data_out}, 64'd1000);
      check("t1_flags", {62'd0, div_by_zero, saturated}, 64'd0);
      check("t1_irdy", {63'd0, in_ready}, 64'd0);
      retire("t1");

      // 2: (-18511-7)<<8 / 384 = -12345.33 -> -12345
      send(-32'sd18511, 32'd7, 16'd384, 5'd8, lat);
      check("t2_lat", 64'(lat), 64'd66);
      check("t2_dout", {32'd0, data_out}, {32'd0, -32'sd12345});
      check("t2_flags", {62'd0, div_by_zero, saturated}, 64'd0);
      retire("t2");

      // 3: zero gain, negative diff
      send(32'd5, 32'd10, 16'd0, 5'd0, lat);
      check("t3_lat", 64'(lat), 64'd2);
      check("t3_dout", {32'd0, data_out}, 64'h8000_0000);
      check("t3_flags", {62'd0, div_by_zero, saturated}, 64'd2);
      retire("t3");

      // 3b: zero gain, non-negative diff
      send(32'd10, 32'd10, 16'd0, 5'd0, lat);
      check("t3b_dout", {32'd0, data_out}, 64'h7FFF_FFFF);
      check("t3b_flags", {62'd0, div_by_zero, saturated}, 64'd2);
      retire("t3b");

      // 4: diff = 2^31, <<4, /1 -> positive overflow
      send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 16'd1, 5'd4, lat);
      check("t4_dout", {32'd0, data_out}, 64'h7FFF_FFFF);
      check("t4_flags", {62'd0, div_by_zero, saturated}, 64'd1);
      retire("t4");

      // 4b: negative overflow, diff = -2^31 - 1, <<4, /1
      send(32'h8000_0000, 32'd1, 16'd1, 5'd4, lat);
      check("t4b_dout", {32'd0, data_out}, 64'h8000_0000);
      check("t4b_flags", {62'd0, div_by_zero, saturated}, 64'd1);
      retire("t4b");

      // gain -32768: 65536 / -32768 = -2
      send(32'd65536, 32'd0, 16'h8000, 5'd0, lat);
      check("gmin_dout", {32'd0, data_out}, {32'd0, -32'sd2});
      check("gmin_flags", {62'd0, div_by_zero, saturated}, 64'd0);
      retire("gmin");

      // 5: stall with an extra in_valid pulse
      send(32'd1000, 32'd0, 16'd256, 5'd8, lat);
      hold = data_out;
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            in_valid = 1'b1;
            data_in  = 32'd5;
            bias     = 32'd0;
            gain     = 16'd0;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
         if (data_out !== hold || in_ready !== 1'b0 || out_valid !== 1'b1)
            ok = 1'b0;
      end
      in_valid = 1'b0;
      check("t5_stable", {63'd0, ok}, 64'd1);
      check("t5_dout", {32'd0, data_out}, 64'd1000);
      retire("t5");
      repeat (5) @(posedge clk);
      #1;
      check("t5_noextra", {62'd0, out_valid, in_ready}, 64'd1);

      // 6: reset during DIVIDE iteration 30
      in_valid = 1'b1;
      data_in  = 32'd1000;
      bias     = 32'd0;
      gain     = 16'd256;
      shift    = 5'd8;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      check("t6_rst_ovalid", {63'd0, out_valid}, 64'd0);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("t6_irdy", {63'd0, in_ready}, 64'd1);
      check("t6_dout", {32'd0, data_out}, 64'd0);
      repeat (70) @(posedge clk);
      #1;
      check("t6_noresult", {63'd0, out_valid}, 64'd0);
      send(32'd1000, 32'd0, 16'd256, 5'd8, lat);
      check("t6_lat", 64'(lat), 64'd66);
      check("t6_res", {32'd0, data_out}, 64'd1000);
      retire("t6");

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
